reboot_ctrl: RTL and testbench

Software-driven reset/reboot request controller in the clk_sys domain. It accepts a reset or warm-boot command from the control bus, waits a programmable hold-off, then does one of two things:
- drives a timed reset-request pulse into the clock/reset manager's rst_in, or
- drives the SB_WARMBOOT primitive (image select plus boot strobe).
It is the requesting end of the system reset path. Commands can be cancelled during the hold-off.

---
 rtl/reboot_ctrl.sv | 121 ++++++++++++
 tb/tb_reboot_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reboot_ctrl.sv
// Software reboot controller: hold-off timer, then a timed reset request toward the
// clock/reset manager or a SB_WARMBOOT image-select + boot strobe.
//
// state       | meaning
// ------------+-----------------------------------------------
// S_IDLE      | ready for a command
// S_ARM       | hold-off countdown, cancellable
// S_RST_PULSE | reset request active for RST_LEN cycles
// S_WB_SETUP  | image select driven, boot strobe still low
// S_BOOT      | boot strobe high, left only through rst
module reboot_ctrl #(
  parameter int DELAY_W  = 16,
  parameter int RST_LEN  = 16,
  parameter int WB_SETUP = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_cmd,
  input  logic [1:0]         req_sel,
  input  logic [DELAY_W-1:0] req_delay,
  input  logic               cancel,
  output logic               busy,
  output logic               pll_rst_req,
  output logic [1:0]         wb_s,
  output logic               wb_boot
);

  localparam int PW = $clog2(RST_LEN + 1);
  localparam int SW = $clog2(WB_SETUP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RST_PULSE,
    S_WB_SETUP,
    S_BOOT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DELAY_W-1:0] r_cnt;
  logic [PW-1:0]      r_pcnt;
  logic [SW-1:0]      r_scnt;
  logic               r_is_wb;
  logic [1:0]         r_sel;
  logic               r_busy;
  logic               r_pll_rst_req;
  logic [1:0]         r_wb_s;
  logic               r_wb_boot;
  logic               w_accept;
  logic               w_cmd_ok;

  assign req_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept  = req_valid & req_ready;
  assign w_cmd_ok  = (req_cmd == 2'b01) | (req_cmd == 2'b10);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept && w_cmd_ok) w_next = S_ARM;
      S_ARM: begin
        // cancel wins over an expiring hold-off
        if (cancel)           w_next = S_IDLE;
        else if (r_cnt == '0) w_next = r_is_wb ? S_WB_SETUP : S_RST_PULSE;
      end
      S_RST_PULSE: if (r_pcnt == '0) w_next = S_IDLE;
      S_WB_SETUP:  if (r_scnt == '0) w_next = S_BOOT;
      S_BOOT:      w_next = S_BOOT;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pcnt        <= '0;
      r_scnt        <= '0;
      r_is_wb       <= 1'b0;
      r_sel         <= 2'b00;
      r_busy        <= 1'b0;
      r_pll_rst_req <= 1'b0;
      r_wb_s        <= 2'b00;
      r_wb_boot     <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE && w_accept) begin
        r_cnt   <= req_delay;
        r_is_wb <= req_cmd[1];
        r_sel   <= req_sel;
      end else if (r_state == S_ARM && r_cnt != '0) begin
        r_cnt <= r_cnt - DELAY_W'(1);
      end

      if (w_next == S_RST_PULSE && r_state != S_RST_PULSE)
        r_pcnt <= PW'(RST_LEN - 1);
      else if (r_state == S_RST_PULSE && r_pcnt != '0)
        r_pcnt <= r_pcnt - PW'(1);

      if (w_next == S_WB_SETUP && r_state != S_WB_SETUP)
        r_scnt <= SW'(WB_SETUP - 1);
      else if (r_state == S_WB_SETUP && r_scnt != '0)
        r_scnt <= r_scnt - SW'(1);

      // outputs are a registered copy of the current state
      r_busy        <= (r_state != S_IDLE);
      r_pll_rst_req <= (r_state == S_RST_PULSE);
      r_wb_s        <= (r_state == S_WB_SETUP || r_state == S_BOOT) ? r_sel : 2'b00;
      r_wb_boot     <= (r_state == S_BOOT);
    end
  end

  assign busy        = r_busy;
  assign pll_rst_req = r_pll_rst_req;
  assign wb_s        = r_wb_s;
  assign wb_boot     = r_wb_boot;

endmodule

// File: tb/tb_reboot_ctrl.sv
// Bench for reboot_ctrl: directed scenarios followed by random traffic, checked
// against a timestamp-based model of accept / action / end cycles.
module tb_reboot_ctrl;

  localparam int DW = 16;
  localparam int RL = 16;
  localparam int WS = 2;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_PULSE = 2;
  localparam int P_SETUP = 3;
  localparam int P_BOOT  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_cmd;
  logic [1:0]    req_sel;
  logic [DW-1:0] req_delay;
  logic          cancel;
  logic          busy;
  logic          pll_rst_req;
  logic [1:0]    wb_s;
  logic          wb_boot;

  always #5 clk = ~clk;

  reboot_ctrl #(.DELAY_W(DW), .RST_LEN(RL), .WB_SETUP(WS)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_sel     (req_sel),
    .req_delay   (req_delay),
    .cancel      (cancel),
    .busy        (busy),
    .pll_rst_req (pll_rst_req),
    .wb_s        (wb_s),
    .wb_boot     (wb_boot)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model: kind 0 = nothing pending, 1 = system reset, 2 = warm boot
  int         m_kind = 0;
  int         m_act  = 0;
  logic [1:0] m_sel  = 2'b00;

  // what the controller is doing right after edge j
  function automatic int phase(input int j);
    if (m_kind == 0) return P_IDLE;
    if (j < m_act)   return P_ARM;
    if (m_kind == 1) return (j < m_act + RL) ? P_PULSE : P_IDLE;
    return (j < m_act + WS) ? P_SETUP : P_BOOT;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] c, input logic [1:0] s,
                      input logic [DW-1:0] d, input logic cn, input logic r);
    int         cur;
    logic       e_pll, e_busy, e_boot;
    logic [1:0] e_s;
    @(negedge clk);
    req_valid = v; req_cmd = c; req_sel = s; req_delay = d; cancel = cn; rst = r;
    #1;
    cur = phase(cyc - 1);
    chk("ready", 32'(req_ready), 32'(cur == P_IDLE && !r));
    if (r) begin
      e_pll = 0; e_busy = 0; e_s = 2'b00; e_boot = 0;
      m_kind = 0;
    end else begin
      e_pll  = (cur == P_PULSE);
      e_busy = (cur != P_IDLE);
      e_s    = (cur == P_SETUP || cur == P_BOOT) ? m_sel : 2'b00;
      e_boot = (cur == P_BOOT);
      if (cur == P_IDLE && v) begin
        if (c == 2'b01 || c == 2'b10) begin
          m_kind = (c == 2'b01) ? 1 : 2;
          m_act  = cyc + int'(d) + 1;
          m_sel  = s;
        end else begin
          m_kind = 0;
        end
      end else if (cur == P_ARM && cn) begin
        m_kind = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("pll_rst_req", 32'(pll_rst_req), 32'(e_pll));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("wb_s",        32'(wb_s),        32'(e_s));
    chk("wb_boot",     32'(wb_boot),     32'(e_boot));
    cyc++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 2'b00, '0, 0, 0);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_cmd = 0; req_sel = 0; req_delay = 0; cancel = 0;

    // reset held with a pending request
    for (int i = 0; i < 3; i++) step(1, 2'b01, 2'b00, 16'd5, 0, 1);

    // system reset, delay 5: first cycle out of reset accepts it
    step(1, 2'b01, 2'b00, 16'd5, 0, 0);
    idle_n(26);

    // zero-delay warm boot, cancel ignored once in setup/boot
    step(1, 2'b10, 2'b10, 16'd0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 2'b00, 2'b00, '0, (i == 1 || i == 50), 0);
    step(0, 2'b00, 2'b00, '0, 0, 1);

    // cancel during hold-off
    step(1, 2'b01, 2'b00, 16'd10, 0, 0);
    idle_n(3);
    step(0, 2'b00, 2'b00, '0, 1, 0);
    idle_n(3);

    // cancel on the expiry cycle
    step(1, 2'b01, 2'b00, 16'd10, 0, 0);
    idle_n(10);
    step(0, 2'b00, 2'b00, '0, 1, 0);
    idle_n(3);

    // no-op accepted and dropped, cancel ignored in idle
    step(1, 2'b00, 2'b00, 16'd3, 1, 0);
    step(1, 2'b11, 2'b01, 16'd3, 0, 0);
    idle_n(3);

    // requests stall while a pulse is running
    step(1, 2'b01, 2'b00, 16'd1, 0, 0);
    for (int i = 0; i < 24; i++) step(1, 2'b01, 2'b00, 16'd2, 0, 0);
    idle_n(30);

    // reset in the middle of a pulse
    step(1, 2'b01, 2'b00, 16'd0, 0, 0);
    idle_n(6);
    step(0, 2'b00, 2'b00, '0, 0, 1);
    idle_n(20);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom),
           DW'($urandom_range(0, 6)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
